// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU-side (I/D) and memory-side signals around mem_port_arbiter.
// master = arbiter view, slave = pipeline + memory model view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    logic              stall;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ready, d_rdata, d_ready,
        output m_req, m_we, m_addr, m_wdata, stall
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  m_req, m_we, m_addr, m_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency single-port memory between fetch (I) and data (D) ports.
// Define ARB_FAIR_EN to bound consecutive D grants while I waits (MAX_D_STREAK).
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } state_t;

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15) begin : g_bad_streak
        $error("MAX_D_STREAK must be in 1..15");
    end

    state_t            state, state_nxt;
    logic              m_req_nxt;
    logic              m_we_nxt;
    logic [ADDR_W-1:0] m_addr_nxt;
    logic [DATA_W-1:0] m_wdata_nxt;
    logic              i_ready_nxt;
    logic              d_ready_nxt;
    logic [DATA_W-1:0] i_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_nxt;
    logic              grant_i;
    logic              grant_d;

`ifdef ARB_FAIR_EN
    logic [3:0] streak, streak_nxt;
    logic       i_starved;

    // I has waited through MAX_D_STREAK back-to-back D grants: it goes next.
    assign i_starved = bus.i_req && (streak == 4'(MAX_D_STREAK));
    assign grant_d   = bus.d_req && !i_starved;
`else
    // D is the older instruction in the pipeline, so it always wins.
    assign grant_d   = bus.d_req;
`endif
    assign grant_i   = bus.i_req && !grant_d;

    assign bus.stall = (bus.i_req && !bus.i_ready) || (bus.d_req && !bus.d_ready);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt   = state;
        m_req_nxt   = bus.m_req;
        m_we_nxt    = bus.m_we;
        m_addr_nxt  = bus.m_addr;
        m_wdata_nxt = bus.m_wdata;
        i_ready_nxt = 1'b0;
        d_ready_nxt = 1'b0;
        i_rdata_nxt = bus.i_rdata;
        d_rdata_nxt = bus.d_rdata;
`ifdef ARB_FAIR_EN
        streak_nxt  = streak;
`endif

        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt   = BUSY_D;
                    m_req_nxt   = 1'b1;
                    m_we_nxt    = bus.d_we;
                    m_addr_nxt  = bus.d_addr;
                    m_wdata_nxt = bus.d_wdata;
`ifdef ARB_FAIR_EN
                    streak_nxt  = bus.i_req ? streak + 4'd1 : 4'd0;
`endif
                end else if (grant_i) begin
                    state_nxt   = BUSY_I;
                    m_req_nxt   = 1'b1;
                    m_we_nxt    = 1'b0;
                    m_addr_nxt  = bus.i_addr;
`ifdef ARB_FAIR_EN
                    streak_nxt  = 4'd0;
`endif
                end
            end

            BUSY_I: begin
                if (bus.m_ack) begin
                    state_nxt   = RESP;
                    m_req_nxt   = 1'b0;
                    m_we_nxt    = 1'b0;
                    i_ready_nxt = 1'b1;
                    i_rdata_nxt = bus.m_rdata;
                end
            end

            BUSY_D: begin
                if (bus.m_ack) begin
                    state_nxt   = RESP;
                    m_req_nxt   = 1'b0;
                    m_we_nxt    = 1'b0;
                    d_ready_nxt = 1'b1;
                    // A store leaves the last load result visible on d_rdata.
                    if (!bus.m_we) begin
                        d_rdata_nxt = bus.m_rdata;
                    end
                end
            end

            // Ready is high for this single cycle; requests are looked at again in IDLE.
            RESP: state_nxt = IDLE;

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
`ifdef ARB_FAIR_EN
            streak      <= 4'd0;
`endif
        end else begin
            state       <= state_nxt;
            bus.m_req   <= m_req_nxt;
            bus.m_we    <= m_we_nxt;
            bus.m_addr  <= m_addr_nxt;
            bus.m_wdata <= m_wdata_nxt;
            bus.i_ready <= i_ready_nxt;
            bus.d_ready <= d_ready_nxt;
            bus.i_rdata <= i_rdata_nxt;
            bus.d_rdata <= d_rdata_nxt;
`ifdef ARB_FAIR_EN
            streak      <= streak_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard queues and a latency-programmable memory model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_rdata;
        int          lat;
        logic [31:0] exp_rdata;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } mreq_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    mreq_t       mq[$];
    rsp_t        rq[$];
    logic [31:0] glog[$];
    logic [31:0] exp_glog[$];
    logic [31:0] last_wdata = '0;

    logic        mdl_ack   = 1'b0;
    logic        spur_ack  = 1'b0;
    logic [31:0] mdl_rdata = '0;
    int          m_cnt     = 0;
    mreq_t       m_e;
    rsp_t        mon_r;
    logic        prev_m_req = 1'b0;

    assign bus.m_ack   = mdl_ack | spur_ack;
    assign bus.m_rdata = mdl_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks lat cycles after m_req rises and checks the request fields.
    always @(posedge clk) begin
        #1;
        if (mdl_ack) begin
            mdl_ack = 1'b0;
            m_cnt   = 0;
        end else if (bus.m_req) begin
            if (mq.size() == 0) begin
                check("unexpected_mreq", bus.m_addr, 32'hFFFF_FFFF);
                mdl_ack = 1'b1;
            end else if (m_cnt >= mq[0].lat) begin
                m_e = mq.pop_front();
                check("m_we", bus.m_we, m_e.we);
                check("m_addr", bus.m_addr, m_e.addr);
                check("m_wdata", bus.m_wdata, m_e.wdata);
                mdl_rdata = m_e.rdata;
                mdl_ack   = 1'b1;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
        end
    end

    // Response monitor: pops the expected response on every ready pulse.
    always @(negedge clk) begin
        if (!rst && (bus.i_ready || bus.d_ready)) begin
            check("ready_exclusive", bus.i_ready & bus.d_ready, 0);
            if (rq.size() == 0) begin
                check("unexpected_ready", {bus.i_ready, bus.d_ready}, 0);
            end else begin
                mon_r = rq.pop_front();
                check("ready_port", bus.d_ready, mon_r.is_d);
                check("rdata", mon_r.is_d ? bus.d_rdata : bus.i_rdata, mon_r.data);
            end
        end
        if (bus.m_req && !prev_m_req) glog.push_back(bus.m_addr);
        prev_m_req = bus.m_req;
    end

    task automatic sb_push(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mem_rdata, input int lat, input logic [31:0] exp_data);
        mreq_t m;
        rsp_t  r;
        m.we    = is_d ? we : 1'b0;
        m.addr  = addr;
        m.wdata = is_d ? wdata : last_wdata;
        m.rdata = mem_rdata;
        m.lat   = lat;
        mq.push_back(m);
        if (is_d) last_wdata = wdata;
        r.is_d = is_d;
        r.data = exp_data;
        rq.push_back(r);
    endtask

    // Called just after a rising edge; returns just after the edge that follows the ready pulse.
    task automatic do_xfer(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_cycles);
        bit done = 1'b0;
        if (is_d) begin
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
            bus.d_req   = 1'b1;
        end else begin
            bus.i_addr = addr;
            bus.i_req  = 1'b1;
        end
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (n == 0) check(is_d ? "stall_d_wait" : "stall_i_wait", bus.stall, 1);
            if (exp_cycles >= 0 && n == 1) check("m_req_busy", bus.m_req, 1);
            if (is_d ? bus.d_ready : bus.i_ready) begin
                done = 1'b1;
                if (exp_cycles >= 0) check(is_d ? "latency_d" : "latency_i", n, exp_cycles);
                if (!(is_d ? bus.i_req : bus.d_req)) check("stall_release", bus.stall, 0);
            end
        end
        if (!done) check(is_d ? "timeout_d" : "timeout_i", 0, 1);
        @(posedge clk);
        #1;
        if (is_d) begin
            bus.d_req = 1'b0;
            bus.d_we  = 1'b0;
        end else begin
            bus.i_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[8];
    int   t_rdy[4];
    bit   fair;

    initial begin
        // is_d, we, addr, wdata, mem_rdata, lat, exp_rdata, exp_cycles
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0050_0093, 3, 32'h0050_0093, 5};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h1111_2222, 0, 32'h1111_2222, 2};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 32'hBAD0_BAD0, 1, 32'h1111_2222, 3};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0, 32'hA5A5_A5A5, 2, 32'hA5A5_A5A5, 4};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0208, 32'h5555_0000, 32'h0000_0000, 4, 32'h0000_0000, 6};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_020C, 32'h1234_5678, 32'hBAD0_BAD0, 0, 32'h0000_0000, 2};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 2};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h8000_0001, 7, 32'h8000_0001, 9};

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_req", bus.m_req, 0);
        check("rst_m_we", bus.m_we, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_m_wdata", bus.m_wdata, 0);
        check("rst_i_ready", bus.i_ready, 0);
        check("rst_d_ready", bus.d_ready, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single transactions on each port with assorted latencies.
        for (int v = 0; v < 8; v++) begin
            sb_push(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].mem_rdata,
                    vecs[v].lat, vecs[v].exp_rdata);
            do_xfer(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_cycles);
        end

        // Contention: D store wins, I fetch follows; d_rdata keeps the last load value.
        sb_push(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 0, 32'h8000_0001);
        sb_push(1'b0, 1'b0, 32'h4, 32'h0, 32'h0000_0013, 0, 32'h0000_0013);
        fork
            do_xfer(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 2);
            do_xfer(1'b0, 1'b0, 32'h4, 32'h0, 5);
        join

        // Zero-latency load stream: one completion every third cycle.
        for (int k = 0; k < 4; k++) begin
            sb_push(1'b1, 1'b0, 32'h500 + 32'(k * 4), 32'h0, 32'h1000_0000 + 32'(k), 0, 32'h1000_0000 + 32'(k));
            do_xfer(1'b1, 1'b0, 32'h500 + 32'(k * 4), 32'h0, 2);
            t_rdy[k] = cyc;
            if (k > 0) check("stream_period", t_rdy[k] - t_rdy[k-1], 3);
        end

        // Reset during the second BUSY_D cycle abandons the load.
        mq.push_back('{1'b0, 32'h300, 32'h0, 32'h7777_7777, 30});
        bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_wdata = 32'h0; bus.d_req = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_busy", bus.m_req, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        check("rst_mid_m_req", bus.m_req, 0);
        check("rst_mid_d_ready", bus.d_ready, 0);
        check("rst_mid_d_rdata", bus.d_rdata, 0);
        check("rst_mid_m_addr", bus.m_addr, 0);
        mq.delete();
        rq.delete();
        last_wdata = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_idle", bus.m_req, 0);
        @(posedge clk);
        #1;
        sb_push(1'b0, 1'b0, 32'h8, 32'h0, 32'h0000_8888, 1, 32'h0000_8888);
        do_xfer(1'b0, 1'b0, 32'h8, 32'h0, 3);

        // Spurious ack in IDLE is ignored.
        spur_ack = 1'b1;
        @(negedge clk);
        check("spur_m_req0", bus.m_req, 0);
        @(posedge clk);
        #1;
        spur_ack = 1'b0;
        @(negedge clk);
        check("spur_m_req1", bus.m_req, 0);
        check("spur_ready", {bus.i_ready, bus.d_ready}, 0);
        @(posedge clk);
        #1;

        // Fairness: D held for six loads while a fetch waits.
`ifdef ARB_FAIR_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        glog.delete();
        for (int k = 0; k < 6; k++) begin
            if (fair && k == 4) begin
                sb_push(1'b0, 1'b0, 32'h40, 32'h0, 32'h3030_3030, 0, 32'h3030_3030);
                exp_glog.push_back(32'h40);
            end
            sb_push(1'b1, 1'b0, 32'h400 + 32'(k * 4), 32'h0, 32'h2000_0000 + 32'(k), 0, 32'h2000_0000 + 32'(k));
            exp_glog.push_back(32'h400 + 32'(k * 4));
        end
        if (!fair) begin
            sb_push(1'b0, 1'b0, 32'h40, 32'h0, 32'h3030_3030, 0, 32'h3030_3030);
            exp_glog.push_back(32'h40);
        end
        fork
            begin
                for (int k = 0; k < 6; k++) do_xfer(1'b1, 1'b0, 32'h400 + 32'(k * 4), 32'h0, -1);
            end
            do_xfer(1'b0, 1'b0, 32'h40, 32'h0, -1);
        join
        check("grant_count", glog.size(), exp_glog.size());
        for (int g = 0; g < exp_glog.size() && g < glog.size(); g++) begin
            check($sformatf("grant_order_%0d", g), glog[g], exp_glog[g]);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mq_drained", mq.size(), 0);
        check("rq_drained", rq.size(), 0);
        check("final_idle", bus.m_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
